// File: rtl/sa_input_feeder.sv
// Feeds the weight-stationary systolic array: latches a weight word, strobes the
// weight load, then streams buffered activation rows with a per-lane diagonal skew.
module sa_input_feeder #(
    parameter int BIT_WIDTH  = 8,
    parameter int SIZE       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               wt_in,
    input  logic                      wt_valid,
    output logic                      wt_ready,
    input  logic [BIT_WIDTH*SIZE-1:0] row_in,
    input  logic                      row_last,
    input  logic                      row_valid,
    output logic                      row_ready,
    output logic                      control,
    output logic [31:0]               wt_arr,
    output logic [BIT_WIDTH*SIZE-1:0] data_arr,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                state_dbg
);

    localparam int ROW_W  = BIT_WIDTH * SIZE;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FCNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_WT = 2'd1,
        STREAM  = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                done_q, done_d;
    logic [31:0]         wt_q, wt_d;

    logic [ROW_W:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push, pop;
    logic [ROW_W:0]      head;
    logic [ROW_W-1:0]    pop_row;
    logic                pop_last;

    // Both handshakes transfer on a rising edge where valid and ready are high together;
    // ready never depends combinationally on valid or on the same-cycle pop.
    assign wt_ready  = (state_q == IDLE);
    assign row_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push      = row_valid && row_ready;
    assign pop       = (state_q == STREAM) && (count_q != '0);
    assign head      = fifo_mem[rd_ptr_q];
    assign pop_row   = pop ? head[ROW_W-1:0] : '0;
    assign pop_last  = pop && head[ROW_W];

    assign control   = (state_q == LOAD_WT);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign wt_arr    = wt_q;
    assign state_dbg = state_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {row_last, row_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        wt_d        = wt_q;
        case (state_q)
            IDLE: begin
                if (wt_valid) begin
                    wt_d    = wt_in;
                    state_d = LOAD_WT;
                end
            end
            LOAD_WT: state_d = STREAM;
            STREAM: begin
                if (pop_last) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FCNT_W'(SIZE - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
            wt_q        <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
            wt_q        <= wt_d;
        end
    end

    // Lane i passes through i+1 registers, so a row popped in cycle t lands on lane i at t+1+i.
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [BIT_WIDTH-1:0] chain_q [i+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= i; j++) chain_q[j] <= '0;
            end else begin
                chain_q[0] <= pop_row[i*BIT_WIDTH +: BIT_WIDTH];
                for (int j = 1; j <= i; j++) chain_q[j] <= chain_q[j-1];
            end
        end

        assign data_arr[i*BIT_WIDTH +: BIT_WIDTH] = chain_q[i];
    end

endmodule

// File: tb/tb_sa_input_feeder.sv
// Directed bench for sa_input_feeder: stimulus pushes expected {done, data_arr} words,
// a negedge monitor pops and compares them while a job is on the array side.
module tb_sa_input_feeder;

    localparam int BW    = 8;
    localparam int SZ    = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wt_in;
    logic        wt_valid;
    logic        wt_ready;
    logic [31:0] row_in;
    logic        row_last;
    logic        row_valid;
    logic        row_ready;
    logic        control;
    logic [31:0] wt_arr;
    logic [31:0] data_arr;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    logic [32:0] exp_q[$];
    logic [31:0] slot_q[$];
    logic [31:0] prefill_tbl [DEPTH];
    logic [32:0] mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;

    always #5 clk = ~clk;

    sa_input_feeder #(.BIT_WIDTH(BW), .SIZE(SZ), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wt_in     (wt_in),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready),
        .row_in    (row_in),
        .row_last  (row_last),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .control   (control),
        .wt_arr    (wt_arr),
        .data_arr  (data_arr),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic exp_push(input logic d, input logic [31:0] v);
        exp_q.push_back({d, v});
    endtask

    // Skewed output formula: lane i in sample c (c=0 is the first STREAM cycle) comes from slot c-1-i.
    task automatic expect_from_slots();
        int          n;
        int          s;
        logic [31:0] v;
        logic [31:0] r;
        n = slot_q.size();
        for (int c = 0; c <= n + SZ; c++) begin
            v = '0;
            for (int i = 0; i < SZ; i++) begin
                s = c - 1 - i;
                if (s >= 0 && s < n) begin
                    r = slot_q[s];
                    v[i*BW +: BW] = r[i*BW +: BW];
                end
            end
            exp_q.push_back({(c == n + SZ), v});
        end
    endtask

    // All driver tasks start and end at posedge+1.
    task automatic push_row(input logic [31:0] r, input logic l);
        row_in    = r;
        row_last  = l;
        row_valid = 1'b1;
        @(posedge clk); #1;
        row_valid = 1'b0;
        row_last  = 1'b0;
    endtask

    task automatic start_job(input logic [31:0] w);
        wt_in    = w;
        wt_valid = 1'b1;
        @(posedge clk); #1;
        wt_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_wt_ready", {31'd0, wt_ready}, 32'd1);
        @(posedge clk); #1;
        check("done_pulse_width", {31'd0, done}, 32'd0);
        check("scoreboard_drain", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && ((busy && !control) || done)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got done=%b data=%h, expected no output", done, data_arr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({done, data_arr} !== mon_e) begin
                    n_fail++;
                    $display("FAIL data_arr_stream: got done=%b data=%h, expected done=%b data=%h",
                             done, data_arr, mon_e[32], mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        prefill_tbl = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D,
                        32'h14131211, 32'h18171615, 32'h1C1B1A19, 32'h201F1E1D};
        rst_n = 1'b0; wt_in = '0; wt_valid = 1'b0;
        row_in = '0; row_last = 1'b0; row_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_control", {31'd0, control}, 32'd0);
        check("rst_wt_arr", wt_arr, 32'd0);
        check("rst_data_arr", data_arr, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_wt_ready", {31'd0, wt_ready}, 32'd1);
        check("idle_row_ready", {31'd0, row_ready}, 32'd1);
        mon_en = 1'b1;

        // Weight load plus a single prefilled row
        push_row(32'h04030201, 1'b1);
        exp_push(1'b0, 32'h00000000);
        exp_push(1'b0, 32'h00000001);
        exp_push(1'b0, 32'h00000200);
        exp_push(1'b0, 32'h00030000);
        exp_push(1'b0, 32'h04000000);
        exp_push(1'b1, 32'h00000000);
        start_job(32'h01010101);
        check("load_wt_arr", wt_arr, 32'h01010101);
        check("load_control", {31'd0, control}, 32'd1);
        check("load_wt_ready", {31'd0, wt_ready}, 32'd0);
        wt_in    = 32'hDEADBEEF;
        wt_valid = 1'b1;
        @(posedge clk); #1;
        wt_valid = 1'b0;
        check("control_one_cycle", {31'd0, control}, 32'd0);
        check("wt_arr_held", wt_arr, 32'h01010101);
        wait_done();

        // Back-to-back rows
        push_row(32'h04030201, 1'b0);
        push_row(32'h08070605, 1'b1);
        exp_push(1'b0, 32'h00000000);
        exp_push(1'b0, 32'h00000001);
        exp_push(1'b0, 32'h00000205);
        exp_push(1'b0, 32'h00030600);
        exp_push(1'b0, 32'h04070000);
        exp_push(1'b0, 32'h08000000);
        exp_push(1'b1, 32'h00000000);
        start_job(32'hA5A5A5A5);
        check("b2b_wt_arr", wt_arr, 32'hA5A5A5A5);
        wait_done();

        // FIFO full after prefill; a ninth row must be refused
        for (int k = 0; k < DEPTH; k++) push_row(prefill_tbl[k], (k == DEPTH - 1));
        check("full_row_ready", {31'd0, row_ready}, 32'd0);
        push_row(32'hEEEEEEEE, 1'b0);
        check("full_row_ready_after_9th", {31'd0, row_ready}, 32'd0);
        slot_q.delete();
        for (int k = 0; k < DEPTH; k++) slot_q.push_back(prefill_tbl[k]);
        expect_from_slots();
        start_job(32'h12345678);
        check("full_ready_load_wt", {31'd0, row_ready}, 32'd0);
        @(posedge clk); #1;
        check("full_ready_first_pop", {31'd0, row_ready}, 32'd0);
        @(posedge clk); #1;
        check("full_ready_after_pop", {31'd0, row_ready}, 32'd1);
        wait_done();

        // Underflow bubbles between rows A and B
        push_row(32'h44332211, 1'b0);
        slot_q.delete();
        slot_q.push_back(32'h44332211);
        slot_q.push_back(32'h00000000);
        slot_q.push_back(32'h00000000);
        slot_q.push_back(32'h88776655);
        expect_from_slots();
        start_job(32'h0F0F0F0F);
        repeat (3) begin @(posedge clk); #1; end
        push_row(32'h88776655, 1'b1);
        wait_done();

        // Asynchronous reset in the middle of streaming
        mon_en = 1'b0;
        push_row(32'h11111111, 1'b0);
        push_row(32'h22222222, 1'b0);
        start_job(32'hCAFEF00D);
        repeat (3) begin @(posedge clk); #1; end
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_data_arr", data_arr, 32'd0);
        check("midrst_control", {31'd0, control}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_wt_arr", wt_arr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_wt_ready", {31'd0, wt_ready}, 32'd1);
        check("postrst_busy", {31'd0, busy}, 32'd0);
        check("postrst_row_ready", {31'd0, row_ready}, 32'd1);
        exp_q.delete();
        mon_en = 1'b1;

        // Job after reset must see only its own row
        push_row(32'h04030201, 1'b1);
        exp_push(1'b0, 32'h00000000);
        exp_push(1'b0, 32'h00000001);
        exp_push(1'b0, 32'h00000200);
        exp_push(1'b0, 32'h00030000);
        exp_push(1'b0, 32'h04000000);
        exp_push(1'b1, 32'h00000000);
        start_job(32'h55AA55AA);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
